// File: rtl/spi_reg_master_if.sv
// Command/response bus of the SPI register initiator.
//   master modport : the requester (drives commands, receives responses)
//   slave modport  : spi_reg_master itself
// Signals:
//   cmd_valid/cmd_ready : command handshake, transfer when both high
//   cmd_we              : 1 = register write, 0 = register read
//   cmd_addr/cmd_wdata  : register address and write data
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata/rsp_err   : read data and readback-mismatch flag
//   busy                : initiator is not idle
`timescale 1ns/1ps
interface spi_reg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/spi_reg_master.sv
// Host-side SPI initiator for the PWM controller's register slave.
// Converts parallel register commands into 24-bit SPI mode-0 frames
// (MSB first): write = {0x01, addr, data}, read = {0x02, addr, 0x00}
// with the read data returned in the third byte on MISO.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   bus (slave)       : command/response bus, see spi_reg_master_if
//   spi_clk_o         : SCLK, idles low
//   spi_ncs_o         : chip select, active low
//   spi_mosi_o        : serial data out
//   spi_miso_i        : serial data in
// Build option: define SPI_MASTER_WRITE_VERIFY_EN to follow every write
// frame with an automatic readback frame and flag mismatches on rsp_err.
`timescale 1ns/1ps
module spi_reg_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spi_reg_master_if.slave  bus,
  output logic             spi_clk_o,
  output logic             spi_ncs_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i
);

  // One shared timer covers setup, half-period, hold and gap intervals.
  localparam int M1      = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2      = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sclk_reg, sclk_next;
  logic [4:0]       bit_reg, bit_next;
  logic [23:0]      tx_reg, tx_next;
  logic [7:0]       rx_reg, rx_next;
  logic             we_reg, we_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [7:0]       rsp_rdata_reg, rsp_rdata_next;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
  logic             vfy_reg, vfy_next;      // current frame is a readback
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       wdata_reg, wdata_next;
  logic             rsp_err_reg, rsp_err_next;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sclk_reg      <= 1'b0;
      bit_reg       <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      we_reg        <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
      vfy_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sclk_reg      <= sclk_next;
      bit_reg       <= bit_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      we_reg        <= we_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
      vfy_reg       <= vfy_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rsp_err_reg   <= rsp_err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    sclk_next      = sclk_reg;
    bit_next       = bit_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    we_next        = we_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
    vfy_next       = vfy_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rsp_err_next   = rsp_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          tx_next    = {bus.cmd_we ? 8'h01 : 8'h02, bus.cmd_addr,
                        bus.cmd_we ? bus.cmd_wdata : 8'h00};
          we_next    = bus.cmd_we;
          cnt_next   = '0;
          state_next = SETUP;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
          vfy_next   = 1'b0;
          addr_next  = bus.cmd_addr;
          wdata_next = bus.cmd_wdata;
`endif
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          cnt_next   = '0;
          sclk_next  = 1'b0;
          bit_next   = '0;
          state_next = SHIFT;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next  = '0;
          sclk_next = ~sclk_reg;
          // End of a high phase: capture MISO and present the next MOSI
          // bit on the same edge that drops SCLK.
          if (sclk_reg) begin
            rx_next  = {rx_reg[6:0], spi_miso_i};
            tx_next  = {tx_reg[22:0], 1'b0};
            bit_next = bit_reg + 5'd1;
            if (bit_reg == 5'd23) state_next = HOLD;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = GAP;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
          // A write frame defers its response to the readback frame.
          if (!we_reg) begin
            rsp_valid_next = 1'b1;
            rsp_rdata_next = rx_reg;
            rsp_err_next   = vfy_reg && (rx_reg != wdata_reg);
          end
`else
          rsp_valid_next = 1'b1;
          rsp_rdata_next = we_reg ? 8'h00 : rx_reg;
`endif
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == IDLE_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
          if (we_reg) begin
            tx_next    = {8'h02, addr_reg, 8'h00};
            we_next    = 1'b0;
            vfy_next   = 1'b1;
            state_next = SETUP;
          end
`endif
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign spi_ncs_o  = !((state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == HOLD));
  assign spi_clk_o  = (state_reg == SHIFT) && sclk_reg;
  assign spi_mosi_o = ((state_reg == SETUP) || (state_reg == SHIFT)) ? tx_reg[23] : 1'b0;

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
  assign bus.rsp_err   = rsp_err_reg;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: unit 0 uses CLK_DIV=4, unit 1 uses CLK_DIV=2.
// Each unit talks to a behavioural SPI register slave (byte memory).
// Expected results come from a register-level model (exp_mem) and the
// frame timing formula, not from the DUT.
`timescale 1ns/1ps
module tb_spi_reg_master;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid [2];
  logic       cmd_we    [2];
  logic [7:0] cmd_addr  [2];
  logic [7:0] cmd_wdata [2];
  logic       cmd_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err   [2];
  logic       busy      [2];
  logic       sclk [2];
  logic       ncs  [2];
  logic       mosi [2];
  logic       miso [2];

  // slave fixture state
  logic [7:0]  smem [2][256];
  bit          szero [2];          // slave answers reads with 0x00
  int          rise_cnt [2], fall_cnt [2];
  logic [23:0] sh [2];
  logic [7:0]  sreply [2];
  logic [23:0] flog [2][8];
  int          flen [2][8];
  int          fcnt [2];
  logic        prev_ncs [2], prev_sclk [2];
  int          rise_cyc [2], last_gap [2];
  int          cyc;

  // reference model of register contents
  logic [7:0]  exp_mem [2][256];

  int tests, fails;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unit
      spi_reg_master_if bus ();
      assign bus.cmd_valid  = cmd_valid[gi];
      assign bus.cmd_we     = cmd_we[gi];
      assign bus.cmd_addr   = cmd_addr[gi];
      assign bus.cmd_wdata  = cmd_wdata[gi];
      assign cmd_ready[gi]  = bus.cmd_ready;
      assign rsp_valid[gi]  = bus.rsp_valid;
      assign rsp_rdata[gi]  = bus.rsp_rdata;
      assign rsp_err[gi]    = bus.rsp_err;
      assign busy[gi]       = bus.busy;
      spi_reg_master #(
        .CLK_DIV  ((gi == 0) ? 4 : 2),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_IDLE  (CS_IDLE)
      ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus.slave),
        .spi_clk_o  (sclk[gi]),
        .spi_ncs_o  (ncs[gi]),
        .spi_mosi_o (mosi[gi]),
        .spi_miso_i (miso[gi])
      );
    end
  endgenerate

  function automatic int div_of(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  function automatic int frame_cycles(input int u);
    return CS_SETUP + 48 * div_of(u) + CS_HOLD;
  endfunction

  // SPI slave model, evaluated just after every clock edge.
  initial begin
    cyc = 0;
    for (int u = 0; u < 2; u++) begin
      prev_ncs[u] = 1'b1; prev_sclk[u] = 1'b0; miso[u] = 1'b0;
      fcnt[u] = 0; rise_cnt[u] = 0; fall_cnt[u] = 0; sh[u] = '0;
      sreply[u] = '0; rise_cyc[u] = 0; last_gap[u] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int u = 0; u < 2; u++) begin
        if (prev_ncs[u] && !ncs[u]) begin
          rise_cnt[u] = 0; fall_cnt[u] = 0; sh[u] = '0;
          last_gap[u] = cyc - rise_cyc[u];
        end else if (!prev_ncs[u] && ncs[u]) begin
          rise_cyc[u] = cyc;
          flog[u][fcnt[u] % 8] = sh[u];
          flen[u][fcnt[u] % 8] = rise_cnt[u];
          fcnt[u]++;
          if (rise_cnt[u] == 24 && sh[u][23:16] == 8'h01)
            smem[u][sh[u][15:8]] = sh[u][7:0];
        end
        if (!ncs[u]) begin
          if (!prev_sclk[u] && sclk[u]) begin
            sh[u] = {sh[u][22:0], mosi[u]};
            rise_cnt[u]++;
          end
          if (prev_sclk[u] && !sclk[u]) begin
            fall_cnt[u]++;
            if (fall_cnt[u] == 16)
              sreply[u] = szero[u] ? 8'h00 : smem[u][sh[u][7:0]];
          end
        end
        if (!ncs[u] && fall_cnt[u] >= 16 && fall_cnt[u] < 24)
          miso[u] = sreply[u][23 - fall_cnt[u]];
        else
          miso[u] = 1'b0;
        prev_ncs[u]  = ncs[u];
        prev_sclk[u] = sclk[u];
      end
    end
  end

  // One complete command with full checking against the model.
  task automatic run_cmd(input int u, input bit we, input logic [7:0] addr, input logic [7:0] data);
    int lat, n, f0, nfr, exp_lat;
    bit bad_ready, extra;
    logic [7:0] exp_rd, rb;
    bit exp_err;
    logic [23:0] exp_f, got_f;
    exp_f = {we ? 8'h01 : 8'h02, addr, we ? data : 8'h00};
    if (we) exp_mem[u][addr] = data;
    rb = szero[u] ? 8'h00 : exp_mem[u][addr];
`ifdef SPI_MASTER_WRITE_VERIFY_EN
    exp_rd  = rb;
    exp_err = we && (rb != data);
    nfr     = we ? 2 : 1;
    exp_lat = we ? 1 + 2 * frame_cycles(u) + CS_IDLE : 1 + frame_cycles(u);
`else
    exp_rd  = we ? 8'h00 : rb;
    exp_err = 1'b0;
    nfr     = 1;
    exp_lat = 1 + frame_cycles(u);
`endif
    @(negedge clk);
    cmd_we[u] = we; cmd_addr[u] = addr; cmd_wdata[u] = data; cmd_valid[u] = 1'b1;
    n = 0;
    while (!cmd_ready[u] && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk);
    f0 = fcnt[u];
    lat = 0; bad_ready = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin cmd_valid[u] = 1'b0; cmd_wdata[u] = ~data; cmd_addr[u] = ~addr; end
      if (rsp_valid[u] || lat >= 5000) break;
      if (cmd_ready[u]) bad_ready = 1;
    end
    $display("[TB] u%0d %s addr=%02h wdata=%02h -> rdata=%02h err=%0b lat=%0d", u,
             we ? "WR" : "RD", addr, data, rsp_rdata[u], rsp_err[u], lat);
    tests++;
    if (!rsp_valid[u]) begin
      fails++; $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", lat);
      return;
    end
    tests++;
    if (lat !== exp_lat) begin fails++; $display("FAIL latency: got %0d expected %0d", lat, exp_lat); end
    tests++;
    if (rsp_rdata[u] !== exp_rd) begin fails++; $display("FAIL rdata: got %02h expected %02h", rsp_rdata[u], exp_rd); end
    tests++;
    if (rsp_err[u] !== exp_err) begin fails++; $display("FAIL rsp_err: got %0b expected %0b", rsp_err[u], exp_err); end
    tests++;
    if (bad_ready !== 1'b0) begin fails++; $display("FAIL ready_in_frame: got %0b expected 0", bad_ready); end
    tests++;
    if (fcnt[u] - f0 !== nfr) begin fails++; $display("FAIL frame_count: got %0d expected %0d", fcnt[u] - f0, nfr); end
    got_f = flog[u][f0 % 8];
    tests++;
    if (got_f !== exp_f) begin fails++; $display("FAIL mosi_frame: got %06h expected %06h", got_f, exp_f); end
    tests++;
    if (flen[u][f0 % 8] !== 24) begin fails++; $display("FAIL sclk_edges: got %0d expected 24", flen[u][f0 % 8]); end
    if (nfr == 2) begin
      got_f = flog[u][(f0 + 1) % 8];
      tests++;
      if (got_f !== {8'h02, addr, 8'h00}) begin
        fails++; $display("FAIL verify_frame: got %06h expected %06h", got_f, {8'h02, addr, 8'h00});
      end
    end
    n = 0; extra = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (rsp_valid[u]) extra = 1;
      if (cmd_ready[u]) break;
    end
    tests++;
    if (extra !== 1'b0) begin fails++; $display("FAIL rsp_pulse_width: got extra pulse %0b expected 0", extra); end
    tests++;
    if (n !== CS_IDLE) begin fails++; $display("FAIL ready_return: got %0d expected %0d", n, CS_IDLE); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      tests++;
      if ({ncs[u], sclk[u], mosi[u], cmd_ready[u], rsp_valid[u], rsp_rdata[u], rsp_err[u], busy[u]} !== {4'b1001, 1'b0, 8'h00, 2'b00}) begin
        fails++;
        $display("FAIL reset_state u%0d: got ncs=%0b sclk=%0b mosi=%0b rdy=%0b vld=%0b rd=%02h err=%0b busy=%0b expected 1 0 0 1 0 00 0 0",
                 u, ncs[u], sclk[u], mosi[u], cmd_ready[u], rsp_valid[u], rsp_rdata[u], rsp_err[u], busy[u]);
      end
    end
    $display("[TB] reset state checked");
  endtask

  task automatic test_write();
    run_cmd(0, 1'b1, 8'h10, 8'hA5);
  endtask

  task automatic test_read();
    smem[0][8'h22] = 8'h3C; exp_mem[0][8'h22] = 8'h3C;
    run_cmd(0, 1'b0, 8'h22, 8'h00);
  endtask

  task automatic test_back_to_back();
    int n, ready_hi;
    bit accepted;
    logic [7:0] d;
    logic [7:0] a;
    d = 8'($urandom); a = 8'h33;
    @(negedge clk);
    cmd_we[0] = 1'b1; cmd_addr[0] = a; cmd_wdata[0] = d; cmd_valid[0] = 1'b1;
    n = 0;
    while (!cmd_ready[0] && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 cmd_we[0] = 1'b0; cmd_wdata[0] = 8'h00;   // second command, valid held
    exp_mem[0][a] = d;
    ready_hi = 0; n = 0;
    while (n < 5000) begin
      @(negedge clk); n++;
      if (rsp_valid[0]) break;
      if (cmd_ready[0]) ready_hi++;
    end
    tests++;
`ifdef SPI_MASTER_WRITE_VERIFY_EN
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== d) begin
      fails++; $display("FAIL b2b_first_rsp: got vld=%0b rd=%02h expected 1 %02h", rsp_valid[0], rsp_rdata[0], d);
    end
`else
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 8'h00) begin
      fails++; $display("FAIL b2b_first_rsp: got vld=%0b rd=%02h expected 1 00", rsp_valid[0], rsp_rdata[0]);
    end
`endif
    n = 0; accepted = 0;
    while (n < 5000) begin
      @(negedge clk); n++;
      if (rsp_valid[0]) break;
      if (cmd_ready[0]) begin
        ready_hi++;
        if (!accepted) begin @(posedge clk); #1 cmd_valid[0] = 1'b0; accepted = 1; end
      end
    end
    $display("[TB] u0 back-to-back WR/RD addr=%02h data=%02h -> rdata=%02h ncs_high=%0d", a, d, rsp_rdata[0], last_gap[0]);
    tests++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== d) begin
      fails++; $display("FAIL b2b_second_rsp: got vld=%0b rd=%02h expected 1 %02h", rsp_valid[0], rsp_rdata[0], d);
    end
    // ncs stays high for the GAP cycles plus the IDLE cycle that accepts.
    tests++;
    if (last_gap[0] !== CS_IDLE + 1) begin fails++; $display("FAIL b2b_ncs_gap: got %0d expected %0d", last_gap[0], CS_IDLE + 1); end
    tests++;
    if (ready_hi !== 1) begin fails++; $display("FAIL b2b_ready_cycles: got %0d expected 1", ready_hi); end
    n = 0;
    while (!cmd_ready[0] && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic test_mid_frame_reset();
    int seen, fidx;
    @(negedge clk);
    cmd_we[0] = 1'b1; cmd_addr[0] = 8'h55; cmd_wdata[0] = ~exp_mem[0][8'h55]; cmd_valid[0] = 1'b1;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    repeat (CS_SETUP + 10 * 2 * 4 + 2) @(negedge clk);   // inside bit 10
    tests++;
    if (ncs[0] !== 1'b0 || busy[0] !== 1'b1) begin
      fails++; $display("FAIL midframe_active: got ncs=%0b busy=%0b expected 0 1", ncs[0], busy[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({ncs[0], sclk[0], cmd_ready[0], busy[0], rsp_valid[0]} !== 5'b10100) begin
      fails++; $display("FAIL midframe_reset: got ncs=%0b sclk=%0b rdy=%0b busy=%0b vld=%0b expected 1 0 1 0 0",
                        ncs[0], sclk[0], cmd_ready[0], busy[0], rsp_valid[0]);
    end
    seen = 0;
    repeat (300) begin @(negedge clk); if (rsp_valid[0] || rsp_valid[1]) seen++; end
    fidx = (fcnt[0] - 1) % 8;
    $display("[TB] u0 reset at bit 10: truncated frame edges=%0d stray_rsp=%0d", flen[0][fidx], seen);
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL midframe_no_rsp: got %0d pulses expected 0", seen); end
    tests++;
    if (flen[0][fidx] !== 10) begin fails++; $display("FAIL midframe_edges: got %0d expected 10", flen[0][fidx]); end
    run_cmd(0, 1'b0, 8'h55, 8'h00);   // truncated write must not have landed
  endtask

  task automatic test_clk_div2();
    smem[1][8'h47] = 8'hC3; exp_mem[1][8'h47] = 8'hC3;
    run_cmd(1, 1'b0, 8'h47, 8'h00);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a, d;
      a = 8'($urandom_range(0, 3)); d = 8'($urandom);
      run_cmd(1, 1'b1, a, d);
      run_cmd(1, 1'b0, a, 8'h00);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int u;
      logic [7:0] a, d;
      u = int'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      run_cmd(u, 1'($urandom_range(0, 1)), a, d);
    end
  endtask

`ifdef SPI_MASTER_WRITE_VERIFY_EN
  task automatic test_verify();
    run_cmd(0, 1'b1, 8'h60, 8'h5A);
    szero[0] = 1'b1;
    run_cmd(0, 1'b1, 8'h61, 8'h5A);
    szero[0] = 1'b0;
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_we[u] = 1'b0; cmd_addr[u] = '0; cmd_wdata[u] = '0;
      szero[u] = 1'b0;
      for (int a = 0; a < 256; a++) begin
        logic [7:0] v;
        v = 8'($urandom);
        smem[u][a] = v; exp_mem[u][a] = v;
      end
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_mid_frame_reset();
    test_clk_div2();
    test_random();
`ifdef SPI_MASTER_WRITE_VERIFY_EN
    test_verify();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule
